// File: rtl/sys_bus_pkg.sv
// Shared definitions for the system-bus watchdog: FSM encoding, bus widths,
// the default error read-data pattern and a saturating increment helper.
package sys_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ORPHAN = 2'd2
    } state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sys_bus_wait_cnt.sv
// Saturating wait counter shared by the WAIT and ORPHAN phases of the watchdog.
// clr_i together with inc_i loads 1, so a new wait can start counting at once.
module sys_bus_wait_cnt #(
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic [CNTW-1:0] term_i,
    output logic            hit_o
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic [CNTW-1:0] base;

    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i && (base != '1)) begin
            cnt_d = base + CNTW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/sys_bus_timeout.sv
// Bus watchdog: forwards strobes/responses with zero latency and forces ack+err
// on a stuck slave. Optional timeout statistics via SYS_BUS_TIMEOUT_STATUS_EN.
module sys_bus_timeout
    import sys_bus_pkg::*;
#(
    parameter int                TIMEOUT     = 256,
    parameter int                CNTW        = 16,
    parameter int                ORPHAN_WAIT = 64,
    parameter logic [DATA_W-1:0] ERR_RDATA   = ERR_RDATA_DEF
) (
    input  logic              sys_clk_i,
    input  logic              sys_rstn_i,
    input  logic [ADDR_W-1:0] m_addr_i,
    input  logic [DATA_W-1:0] m_wdata_i,
    input  logic [SEL_W-1:0]  m_sel_i,
    input  logic              m_wen_i,
    input  logic              m_ren_i,
    output logic [DATA_W-1:0] m_rdata_o,
    output logic              m_err_o,
    output logic              m_ack_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic              s_wen_o,
    output logic              s_ren_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic              s_err_i,
    input  logic              s_ack_i,
    output logic              proto_err_o
`ifdef SYS_BUS_TIMEOUT_STATUS_EN
    ,
    output logic [31:0]       to_cnt_o,
    output logic [31:0]       to_addr_o
`endif
);

    state_e          state_q;
    state_e          state_d;
    logic            proto_q;
    logic            proto_d;
    logic            strobe;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            cnt_hit;
    logic [CNTW-1:0] cnt_term;

    assign strobe    = m_wen_i | m_ren_i;
    assign s_addr_o  = m_addr_i;
    assign s_wdata_o = m_wdata_i;
    assign s_sel_o   = m_sel_i;

    // One counter serves both phases; only the terminal value changes.
    assign cnt_term = (state_q == ST_WAIT) ? CNTW'(TIMEOUT) : CNTW'(ORPHAN_WAIT);

    sys_bus_wait_cnt #(
        .CNTW (CNTW)
    ) u_wait_cnt (
        .clk_i  (sys_clk_i),
        .rst_ni (sys_rstn_i),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .term_i (cnt_term),
        .hit_o  (cnt_hit)
    );

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q <= ST_IDLE;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            proto_q <= proto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        proto_d = proto_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (strobe && !s_ack_i) begin
                    state_d = ST_WAIT;
                    cnt_inc = 1'b1;
                end
            end
            ST_WAIT: begin
                if (strobe) begin
                    proto_d = 1'b1;
                end
                // A slave ack in the timeout cycle takes priority over the forced error.
                if (s_ack_i) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_hit) begin
                    state_d = ST_ORPHAN;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_ORPHAN: begin
                if (s_ack_i || cnt_hit) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        s_wen_o   = 1'b0;
        s_ren_o   = 1'b0;
        m_ack_o   = 1'b0;
        m_err_o   = 1'b0;
        m_rdata_o = '0;
        if (sys_rstn_i) begin
            case (state_q)
                ST_IDLE: begin
                    s_wen_o = m_wen_i;
                    s_ren_o = m_ren_i;
                    if (strobe && s_ack_i) begin
                        m_ack_o   = 1'b1;
                        m_err_o   = s_err_i;
                        m_rdata_o = s_rdata_i;
                    end
                end
                ST_WAIT: begin
                    if (s_ack_i) begin
                        m_ack_o   = 1'b1;
                        m_err_o   = s_err_i;
                        m_rdata_o = s_rdata_i;
                    end else if (cnt_hit) begin
                        m_ack_o   = 1'b1;
                        m_err_o   = 1'b1;
                        m_rdata_o = ERR_RDATA;
                    end
                end
                ST_ORPHAN: begin
                    // Fail fast: the slave is still presumed busy with the abandoned access.
                    if (strobe) begin
                        m_ack_o   = 1'b1;
                        m_err_o   = 1'b1;
                        m_rdata_o = ERR_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign proto_err_o = proto_q;

`ifdef SYS_BUS_TIMEOUT_STATUS_EN
    logic        to_fire;
    logic [31:0] req_addr_q;
    logic [31:0] req_addr_d;
    logic [31:0] to_cnt_q;
    logic [31:0] to_cnt_d;
    logic [31:0] to_addr_q;
    logic [31:0] to_addr_d;

    assign to_fire = (state_q == ST_WAIT) && !s_ack_i && cnt_hit;

    // The address is captured at the strobe because the master may change it afterwards.
    always_comb begin
        req_addr_d = req_addr_q;
        to_cnt_d   = to_cnt_q;
        to_addr_d  = to_addr_q;
        if ((state_q == ST_IDLE) && strobe) begin
            req_addr_d = m_addr_i;
        end
        if (to_fire) begin
            to_cnt_d  = sat_inc32(to_cnt_q);
            to_addr_d = req_addr_q;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            req_addr_q <= '0;
            to_cnt_q   <= '0;
            to_addr_q  <= '0;
        end else begin
            req_addr_q <= req_addr_d;
            to_cnt_q   <= to_cnt_d;
            to_addr_q  <= to_addr_d;
        end
    end

    assign to_cnt_o  = to_cnt_q;
    assign to_addr_o = to_addr_q;
`endif

endmodule

// File: tb/tb_sys_bus_timeout.sv
// Scoreboard bench for sys_bus_timeout: the driver derives each expected master
// response from transaction timing; a negedge monitor pops and compares it.
module tb_sys_bus_timeout;

    localparam int          T    = 256;
    localparam int          OW   = 64;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, s_rdata = '0;
    logic [3:0]  m_sel = '0;
    logic        m_wen = 1'b0, m_ren = 1'b0, s_err = 1'b0, s_ack = 1'b0;
    logic [31:0] m_rdata_o, s_addr_o, s_wdata_o;
    logic [3:0]  s_sel_o;
    logic        m_err_o, m_ack_o, s_wen_o, s_ren_o, proto_err_o;
`ifdef SYS_BUS_TIMEOUT_STATUS_EN
    logic [31:0] to_cnt_o, to_addr_o;
`endif

    sys_bus_timeout #(.TIMEOUT(T), .CNTW(16), .ORPHAN_WAIT(OW), .ERR_RDATA(ERRD)) dut (
        .sys_clk_i   (clk),
        .sys_rstn_i  (rstn),
        .m_addr_i    (m_addr),
        .m_wdata_i   (m_wdata),
        .m_sel_i     (m_sel),
        .m_wen_i     (m_wen),
        .m_ren_i     (m_ren),
        .m_rdata_o   (m_rdata_o),
        .m_err_o     (m_err_o),
        .m_ack_o     (m_ack_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_sel_o     (s_sel_o),
        .s_wen_o     (s_wen_o),
        .s_ren_o     (s_ren_o),
        .s_rdata_i   (s_rdata),
        .s_err_i     (s_err),
        .s_ack_i     (s_ack),
        .proto_err_o (proto_err_o)
`ifdef SYS_BUS_TIMEOUT_STATUS_EN
        ,
        .to_cnt_o    (to_cnt_o),
        .to_addr_o   (to_addr_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] rd;
    } exp_t;
    exp_t exp_q[$];

    bit          proto_m = 1'b0;
    logic [31:0] to_cnt_m = '0;
    logic [31:0] to_addr_m = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic expect_ack(input bit err, input logic [31:0] rd);
        exp_t e;
        e.cyc = cyc;
        e.err = err;
        e.rd  = rd;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack must match the oldest expected response, otherwise outputs are idle.
    exp_t me;
    always @(negedge clk) begin
        if (m_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {31'd0, m_ack_o}, 32'd0);
            end else begin
                me = exp_q.pop_front();
                chk("ack_time", cyc, me.cyc);
                chk("ack_err", {31'd0, m_err_o}, {31'd0, me.err});
                chk("ack_rdata", m_rdata_o, me.rd);
            end
        end else begin
            chk("idle_outputs", {m_rdata_o[30:0], m_err_o}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        m_wen   = 1'b0;
        m_ren   = 1'b0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rdata = $urandom;
        m_addr  = $urandom;
        m_wdata = $urandom;
        m_sel   = 4'($urandom);
    endtask

    task automatic check_state();
        chk("proto_err", {31'd0, proto_err_o}, {31'd0, proto_m});
`ifdef SYS_BUS_TIMEOUT_STATUS_EN
        chk("to_cnt", to_cnt_o, to_cnt_m);
        chk("to_addr", to_addr_o, to_addr_m);
`endif
    endtask

    // lat: cycles from strobe to slave ack (lat > T means the slave never answers in time).
    // late: orphan-phase cycle of a late ack (<=0 none); os: orphan-phase cycle of a new
    // strobe (0 none); ws: wait-phase cycle of an illegal strobe (0 none).
    task automatic access(input bit wr, input logic [31:0] addr, input int lat, input bit serr,
                          input logic [31:0] srd, input int late, input int os, input int ws);
        int end_j;
        step();
        m_addr = addr;
        if (wr) m_wen = 1'b1;
        else    m_ren = 1'b1;
        if (lat == 0) begin
            s_ack = 1'b1; s_err = serr; s_rdata = srd;
            expect_ack(serr, srd);
        end
        #1;
        chk("s_wen_fwd", {31'd0, s_wen_o}, {31'd0, wr});
        chk("s_ren_fwd", {31'd0, s_ren_o}, {31'd0, !wr});
        chk("s_addr_fwd", s_addr_o, addr);
        chk("s_wdata_fwd", s_wdata_o, m_wdata);
        chk("s_sel_fwd", {28'd0, s_sel_o}, {28'd0, m_sel});
        if (lat > 0) begin
            for (int k = 1; k <= T && k <= lat; k++) begin
                step();
                if (k == ws) begin
                    if (wr) m_ren = 1'b1;
                    else    m_wen = 1'b1;
                end
                if (k == lat) begin
                    s_ack = 1'b1; s_err = serr; s_rdata = srd;
                    expect_ack(serr, srd);
                end else if (k == T) begin
                    expect_ack(1'b1, ERRD);
                    if (to_cnt_m != 32'hFFFF_FFFF) to_cnt_m = to_cnt_m + 1;
                    to_addr_m = addr;
                end
                if (k == ws) begin
                    #1;
                    chk("wait_strobe_blocked", {30'd0, s_wen_o, s_ren_o}, 32'd0);
                    proto_m = 1'b1;
                end
            end
            if (lat > T) begin
                end_j = (late > 0) ? late : OW + 1;
                for (int j = 1; j <= end_j; j++) begin
                    step();
                    if (j == late) begin
                        s_ack = 1'b1; s_err = 1'($urandom);
                    end
                    if (j == os) begin
                        m_ren = 1'b1;
                        expect_ack(1'b1, ERRD);
                        #1;
                        chk("orphan_strobe_blocked", {30'd0, s_wen_o, s_ren_o}, 32'd0);
                    end
                end
            end
        end
        step();
        check_state();
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            step();
            if ($urandom % 4 == 0) begin
                s_ack = 1'b1; s_err = 1'($urandom);
            end
        end
    endtask

    task automatic reset_in_wait();
        step();
        m_addr = 32'h40; m_ren = 1'b1;
        #1;
        chk("rst_test_fwd", {31'd0, s_ren_o}, 32'd1);
        repeat (5) step();
        rstn = 1'b0; m_ren = 1'b1; s_ack = 1'b1; s_err = 1'b1;
        #1;
        chk("rst_gate", {28'd0, s_wen_o, s_ren_o, m_ack_o, m_err_o}, 32'd0);
        proto_m = 1'b0; to_cnt_m = '0; to_addr_m = '0;
        step();
        rstn = 1'b1;
        step();
        s_ack = 1'b1;
        step();
        check_state();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit          wr;
        int          r, lat, late, os, ws, lim;
        logic [31:0] addr;

        rstn = 1'b0;
        repeat (3) begin
            step();
            m_ren = 1'b1; m_wen = 1'b1; s_ack = 1'b1; s_err = 1'b1;
            #1;
            chk("reset_gate", {27'd0, s_wen_o, s_ren_o, m_ack_o, m_err_o, proto_err_o}, 32'd0);
        end
        step();
        rstn = 1'b1;
        step();
        check_state();

        access(1'b0, 32'h04, 0, 1'b0, 32'h1234, 0, 0, 0);
        access(1'b1, 32'h30, 5, 1'b0, 32'h0, 0, 0, 0);
        access(1'b0, 32'h24, T + 1, 1'b0, 32'h0, 10, 0, 0);
        access(1'b0, 32'h08, 1, 1'b0, 32'h5678, 0, 0, 0);
        access(1'b0, 32'h0C, T, 1'b1, 32'hA5A5, 0, 0, 0);
        access(1'b0, 32'h10, 6, 1'b0, 32'h9, 0, 0, 2);
        access(1'b1, 32'h14, T + 1, 1'b0, 32'h0, 0, 3, 0);
        reset_in_wait();
        access(1'b0, 32'h18, 2, 1'b1, 32'hCAFE, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            r    = $urandom % 20;
            wr   = 1'($urandom);
            addr = $urandom;
            if (r < 7)       lat = 0;
            else if (r < 14) lat = 1 + $urandom % 8;
            else if (r < 16) lat = 9 + $urandom % (T - 9);
            else if (r == 16) lat = T;
            else             lat = T + 1;
            late = 0; os = 0; ws = 0;
            if (lat > T) begin
                if ($urandom % 3 != 0) late = 1 + $urandom % (OW + 8);
                lim = (late > 0 && late < OW + 1) ? late : OW + 1;
                if ($urandom % 2 == 0) os = 1 + $urandom % lim;
            end
            if (lat > 0 && $urandom % 12 == 0) ws = 1 + $urandom % ((lat > T) ? T : lat);
            access(wr, addr, lat, 1'($urandom), $urandom, late, os, ws);
            gap($urandom % 4);
        end

        gap(5);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sys_bus_timeout.md
Name: sys_bus_timeout

Overview:
- Bus watchdog between the system-bus master (PS AXI bridge / sys_bus_model in benches) and one slave such as red_pitaya_hk.
- Forwards read/write strobes and responses with zero added latency.
- If the slave does not acknowledge within TIMEOUT cycles, it terminates the access itself with ack+err, so a dead or unclocked slave cannot hang the CPU.
- Late acks from the abandoned access are swallowed.

Parameters:
- TIMEOUT, 256: cycles after the strobe cycle before a forced error response; legal range 2..2^CNTW-1.
- CNTW, 16: width of the wait counter.
- ORPHAN_WAIT, 64: maximum cycles to wait for a late slave ack after a timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a forced error response.

Ports:
- sys_clk_i  in  1  system-bus clock
- sys_rstn_i  in  1  asynchronous active-low reset
- m_addr_i  in  32  master address
- m_wdata_i  in  32  master write data
- m_sel_i  in  4  master byte select
- m_wen_i  in  1  master write strobe (1-cycle pulse)
- m_ren_i  in  1  master read strobe (1-cycle pulse)
- m_rdata_o  out  32  read data to master
- m_err_o  out  1  error to master
- m_ack_o  out  1  acknowledge to master
- s_addr_o  out  32  slave address (= m_addr_i)
- s_wdata_o  out  32  slave write data (= m_wdata_i)
- s_sel_o  out  4  slave byte select (= m_sel_i)
- s_wen_o  out  1  gated write strobe to slave
- s_ren_o  out  1  gated read strobe to slave
- s_rdata_i  in  32  slave read data
- s_err_i  in  1  slave error
- s_ack_i  in  1  slave acknowledge
- proto_err_o  out  1  sticky: strobe issued while an access was pending

Behaviour:
- States: IDLE, WAIT, ORPHAN. Reset → IDLE, cnt=0, proto_err_o=0.
- While sys_rstn_i=0: s_wen_o, s_ren_o, m_ack_o and m_err_o are forced to 0.
- IDLE:
  - m_wen_i/m_ren_i forwarded combinationally to s_wen_o/s_ren_o.
  - A same-cycle s_ack_i is forwarded (m_ack_o=1, m_err_o=s_err_i, m_rdata_o=s_rdata_i); state stays IDLE.
  - A strobe without s_ack_i → WAIT, cnt=1.
  - s_ack_i with no strobe is dropped (m_ack_o=0).
- WAIT:
  - cnt increments each cycle.
  - s_ack_i is forwarded → IDLE.
  - If no ack and cnt==TIMEOUT: m_ack_o=1, m_err_o=1, m_rdata_o=ERR_RDATA for that single cycle → ORPHAN, cnt=0.
  - If s_ack_i arrives in the timeout cycle, the slave response wins.
  - Any strobe in WAIT is not forwarded, gets no response, and sets proto_err_o.
- ORPHAN:
  - s_ack_i is dropped → IDLE.
  - cnt reaching ORPHAN_WAIT → IDLE.
  - A strobe in ORPHAN is not forwarded; it is answered the same cycle with ack+err+ERR_RDATA (fail-fast).
- Outside forwarded or forced responses: m_rdata_o=0, m_ack_o=0, m_err_o=0.
- Counter saturates; no wrap possible because TIMEOUT and ORPHAN_WAIT are both < 2^CNTW.
- proto_err_o clears only on reset.
- Reset mid-access: immediate return to IDLE; a later ack from the slave is dropped by the IDLE rule.
- Address/data/sel are forwarded unconditionally: pure wires, no latency.

Optional Feature:
- Macro: SYS_BUS_TIMEOUT_STATUS_EN.
- When defined, adds outputs to_cnt_o[32] and to_addr_o[32]:
  - to_cnt_o is a saturating count of forced timeouts.
  - to_addr_o is the address of the last timed-out access, captured at the strobe cycle.
  - Both reset to 0.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package sys_bus_pkg: state encoding (IDLE/WAIT/ORPHAN), bus width constants (ADDR_W=32, DATA_W=32, SEL_W=4), default ERR_RDATA.
- One sub-module is natural: sys_bus_wait_cnt, a saturating counter with clear and terminal-compare outputs, reused for the WAIT and ORPHAN phases.

Test Plan:
- Zero-wait slave: read at 0x04 with s_ack_i in the same cycle, s_rdata_i=0x1234 → m_ack_o=1 that cycle, m_rdata_o=0x1234, m_err_o=0, state IDLE.
- Slave ack 5 cycles late on write 0x30=0x3 → s_wen_o 1 cycle, m_ack_o exactly 5 cycles after the strobe, m_err_o=0, no proto_err_o.
- Dead slave, TIMEOUT=256, read at 0x24 → m_ack_o=m_err_o=1, m_rdata_o=0xDEADBEEF exactly 256 cycles after the strobe; with status enabled, to_cnt_o=1 and to_addr_o=0x24.
- Late ack 10 cycles after the timeout → m_ack_o stays 0, state back to IDLE; a following read at 0x08 with a 1-cycle ack completes normally.
- Strobe during WAIT → s_ren_o stays 0, proto_err_o=1 and stays 1 until reset; strobe during ORPHAN → same-cycle ack+err with ERR_RDATA.
- sys_rstn_i pulsed low during WAIT → outputs 0 immediately, state IDLE; the slave's post-reset ack is not forwarded.
